// File: rtl/clock_tick_scheduler.sv
// clock_tick_scheduler: timebase controller for the digital clock. Turns the
// system clock into one-cycle enables: gated 1 Hz second advance, display scan
// strobe, set-mode blink level and rate-limited adjust pulses with hold-repeat.
module clock_tick_scheduler #(
    parameter int CLK_Freq   = 24000000,
    parameter int SCAN_Freq  = 1000,
    parameter int BLINK_Freq = 2,
    parameter int FAST_Freq  = 8
) (
    input  logic       CLK_12,
    input  logic       nCR,
    input  logic       start,
    input  logic       pause,
    input  logic       set_en,
    input  logic       adj_key,
    output logic       sec_tick,
    output logic       adj_tick,
    output logic       scan_tick,
    output logic       blink,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        SET   = 2'b11
    } state_t;

    localparam int SEC_P  = CLK_Freq;
    localparam int SCAN_P = CLK_Freq / SCAN_Freq;
    localparam int BLK_P  = CLK_Freq / (2 * BLINK_Freq);
    localparam int REP_P  = CLK_Freq / FAST_Freq;
    localparam int HOLD_P = CLK_Freq / 2;

    localparam int SEC_W  = (SEC_P  > 1) ? $clog2(SEC_P)  : 1;
    localparam int SCAN_W = (SCAN_P > 1) ? $clog2(SCAN_P) : 1;
    localparam int BLK_W  = (BLK_P  > 1) ? $clog2(BLK_P)  : 1;
    localparam int HOLD_W = (HOLD_P > 1) ? $clog2(HOLD_P) : 1;

    localparam logic [SEC_W-1:0]  SEC_LAST    = SEC_W'(SEC_P - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST   = SCAN_W'(SCAN_P - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST    = BLK_W'(BLK_P - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_P - 1);
    // Reloading to HOLD_P-REP_P makes every later repeat land REP_P cycles apart.
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_P - REP_P);

    state_t              state_q, state_d;
    logic [SEC_W-1:0]    sec_cnt_q, sec_cnt_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                set_prev_q, set_prev_d;
    logic                hold_act_q, hold_act_d;
    logic                adj_q, adj_d;
    logic                sec_tick_q, sec_tick_d;
    logic                adj_tick_q, adj_tick_d;
    logic                scan_tick_q, scan_tick_d;
    logic                blink_q, blink_d;

    // Next-state logic: set_en overrides everything, then pause, then start.
    always_comb begin
        // NOTE: assign a default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (set_en) begin
            state_d = SET;
        end else begin
            unique case (state_q)
                IDLE:  if (start) state_d = RUN;
                RUN:   if (pause) state_d = PAUSE;
                PAUSE: if (!pause && start) state_d = RUN;
                SET:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK_12 or negedge nCR) begin
        if (!nCR) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Prescalers, blink and adjust datapath; all tick decisions use the registered state.
    always_comb begin
        // Scan strobe runs in every state.
        scan_tick_d = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d  = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;

        // Seconds: count in RUN, freeze in PAUSE so resume finishes the second.
        sec_tick_d = 1'b0;
        sec_cnt_d  = '0;
        if (state_q == RUN) begin
            if (sec_cnt_q == SEC_LAST) begin
                sec_tick_d = 1'b1;
            end else begin
                sec_cnt_d = sec_cnt_q + 1'b1;
            end
        end else if (state_q == PAUSE) begin
            sec_cnt_d = sec_cnt_q;
        end

        // Blink: counter stays clear through the first SET cycle, then free-runs.
        set_prev_d = (state_q == SET);
        blk_cnt_d  = '0;
        blink_d    = blink_q;
        if (state_q == SET && set_prev_q) begin
            if (blk_cnt_q == BLK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
        if (state_d != SET) begin
            blink_d = 1'b1;
        end

        // Adjust: a fresh rise in SET fires at once and arms hold-to-repeat.
        adj_d      = adj_key;
        adj_tick_d = 1'b0;
        hold_act_d = hold_act_q;
        hold_cnt_d = hold_cnt_q;
        if (state_q != SET || !adj_key) begin
            hold_act_d = 1'b0;
            hold_cnt_d = '0;
        end else if (!adj_q) begin
            adj_tick_d = 1'b1;
            hold_act_d = 1'b1;
            hold_cnt_d = '0;
        end else if (hold_act_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
                adj_tick_d = 1'b1;
                hold_cnt_d = HOLD_RELOAD;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    // Datapath registers; every output is driven straight from a flop.
    always_ff @(posedge CLK_12 or negedge nCR) begin
        if (!nCR) begin
            sec_cnt_q   <= '0;
            scan_cnt_q  <= '0;
            blk_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            set_prev_q  <= 1'b0;
            hold_act_q  <= 1'b0;
            adj_q       <= 1'b0;
            sec_tick_q  <= 1'b0;
            adj_tick_q  <= 1'b0;
            scan_tick_q <= 1'b0;
            blink_q     <= 1'b1;
        end else begin
            sec_cnt_q   <= sec_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            set_prev_q  <= set_prev_d;
            hold_act_q  <= hold_act_d;
            adj_q       <= adj_d;
            sec_tick_q  <= sec_tick_d;
            adj_tick_q  <= adj_tick_d;
            scan_tick_q <= scan_tick_d;
            blink_q     <= blink_d;
        end
    end

    assign sec_tick  = sec_tick_q;
    assign adj_tick  = adj_tick_q;
    assign scan_tick = scan_tick_q;
    assign blink     = blink_q;
    assign state     = state_q;

endmodule

// File: doc/clock_tick_scheduler.md
# clock_tick_scheduler

Controller that sequences the digital clock's timebase. From the single 24 MHz system clock it produces one-cycle clock-enable pulses:
- the 1 Hz second advance, gated by a run/pause/set state machine;
- the display scan strobe;
- the set-mode blink level;
- rate-limited adjust pulses with hold-to-repeat.

It sits between the key debouncers and the time-of-day counters/display mux, and replaces free-running square-wave division with gated enables.

## Interface
Parameters:
- CLK_Freq, 24000000, system clock cycles per second
- SCAN_Freq, 1000, scan strobe rate (Hz)
- BLINK_Freq, 2, blink square-wave rate (Hz)
- FAST_Freq, 8, adjust auto-repeat rate (Hz)

Ports:
- CLK_12  in  1  system clock; all logic on rising edge
- nCR  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, run/resume
- pause  in  1  one-cycle pulse, pause
- set_en  in  1  level, set mode while high
- adj_key  in  1  debounced level, adjust key held
- sec_tick  out  1  one-cycle pulse, advance seconds
- adj_tick  out  1  one-cycle pulse, advance selected field
- scan_tick  out  1  one-cycle pulse at SCAN_Freq
- blink  out  1  display-enable level for the field being set
- state  out  2  IDLE=00, RUN=01, PAUSE=10, SET=11

## Operation
- **Derived constants** (integer division):
  - SEC_P = CLK_Freq
  - SCAN_P = CLK_Freq/SCAN_Freq
  - BLK_P = CLK_Freq/(2·BLINK_Freq)
  - REP_P = CLK_Freq/FAST_Freq
  - HOLD_P = CLK_Freq/2
  - Counter widths are $clog2 of the respective period.
- **State machine** (registered). Input priority: set_en > pause > start.
  - IDLE: start→RUN.
  - RUN: pause→PAUSE.
  - PAUSE: start→RUN.
  - any state with set_en=1 → SET.
  - SET with set_en=0 → RUN.
  - Otherwise hold.
- **Second prescaler sec_cnt**:
  - RUN: increments; at SEC_P−1 wraps to 0 and fires sec_tick.
  - PAUSE: holds its value, so a resume completes the interrupted second.
  - IDLE/SET: forced to 0. Leaving SET therefore starts a full fresh second.
- **Scan prescaler**: free-running in all states. It wraps at SCAN_P−1 and fires scan_tick.
- **Blink**:
  - blink=1 in every state except SET.
  - On entry to SET, the blink counter is cleared and blink=1.
  - blink toggles each time the blink counter wraps at BLK_P−1.
- **Adjust** (SET only):
  - adj_key is registered into adj_q; a rise is detected when adj_key=1 and adj_q=0.
  - A rise fires adj_tick and clears hold_cnt.
  - While adj_key stays high, hold_cnt counts. The first repeat fires HOLD_P cycles after the rise; further repeats fire every REP_P cycles.
  - Releasing the key, or leaving SET, cancels the hold immediately with no further pulses.
  - adj_key is ignored outside SET, including a key already held when SET is entered: a fresh rise is required.
- sec_tick and adj_tick are mutually exclusive by construction.

## Timing
- **Reset values**: state=00, sec_tick=0, adj_tick=0, scan_tick=0, blink=1. All counters are 0 and adj_q=0.
- **Output registration**: all outputs are registered and no pulse is wider than one cycle.
- **State change**: takes effect after the sampling edge; state reflects the new value one cycle after the input.
- **First sec_tick**: start sampled at edge 0 → first sec_tick high after edge SEC_P, then every SEC_P cycles.
- **Pause/resume**: pause at edge p with sec_cnt=k, resume at edge r → next sec_tick after edge r+(SEC_P−k).
- **Adjust pulses**: rise sampled at edge e → adj_tick after edges e, e+HOLD_P, e+HOLD_P+REP_P, …
- **Simultaneous inputs**:
  - pause and start in the same cycle in RUN → PAUSE.
  - start and set_en together → SET.
  - A sec_tick due in the same cycle as a pause sampling edge is still emitted (count reached wrap before the transition).
- **Reset mid-operation**: asynchronous assertion forces all reset values immediately; release restarts from IDLE.

## Test plan
All scenarios use CLK_Freq=40, SCAN_Freq=10, BLINK_Freq=2, FAST_Freq=8, giving SEC_P=40, SCAN_P=4, BLK_P=10, REP_P=5, HOLD_P=20.
1. Reset, then start at edge 0 → state=01; sec_tick after edges 40, 80, 120 only. scan_tick every 4 cycles from reset, including in IDLE.
2. Start at 0, pause at 15, start at 50 → state=10 during 16..50; no sec_tick before edge 75; next one at 115.
3. set_en high at edge 30 in RUN, adj_key rise at 40 held to 70 → adj_tick after 40, 60, 65, 70. No sec_tick while SET. blink=1 at 31, toggles at 41, 51, 61…
4. set_en drops at edge 100 → state=01, blink=1, first sec_tick after edge 140. An adj_key pulse in RUN gives no adj_tick.
5. start and pause together in RUN → PAUSE. adj_key held across SET entry → no adj_tick until release and re-press.
6. nCR low mid-hold in SET at arbitrary phase → outputs immediately at reset values. After release, state=00 and no ticks except scan_tick.
